// File: rtl/naneye_upstream_ctrl.sv
// NanEye upstream configuration controller.
// Holds one host configuration word until the upstream window that opens after
// a frame-end marker, then Manchester-encodes {start bit, word} MSB first onto
// the shared sensor line. A new frame sync during transmission aborts and the
// word is retried at the next window.
module naneye_upstream_ctrl #(
  parameter int WORD_W   = 16,
  parameter int HALF_BIT = 6,
  parameter int UP_DLY   = 20,
  parameter int CNT_W    = 8
) (
  input  logic              SCLOCK,
  input  logic              RESET,
  input  logic              FRAME_END,
  input  logic              FRAME_SYNC,
  input  logic              CFG_REQ,
  input  logic [WORD_W-1:0] CFG_WORD,
  output logic              CFG_BUSY,
  output logic              CFG_DONE,
  output logic              CFG_ERR,
  output logic              SDATA_OUT,
  output logic              SDATA_OE
);

  localparam int BC_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(UP_DLY - 1);
  localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(HALF_BIT - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(WORD_W);

  typedef enum logic [2:0] {IDLE, PEND, DELAY, SEND, STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BC_W-1:0]     bcnt_q, bcnt_d;
  logic                ph_q, ph_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W:0]     sr_q, sr_d;
  logic                fsync_q, fsync_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                out_q, out_d;
  logic                oe_q, oe_d;
  logic                sync_edge;

  assign CFG_BUSY  = busy_q;
  assign CFG_DONE  = done_q;
  assign CFG_ERR   = err_q;
  assign SDATA_OUT = out_q;
  assign SDATA_OE  = oe_q;

  // Next-state, counters and registered line outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcnt_d    = bcnt_q;
    ph_d      = ph_q;
    word_d    = word_q;
    sr_d      = sr_q;
    out_d     = out_q;
    oe_d      = oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fsync_d   = FRAME_SYNC;
    sync_edge = FRAME_SYNC & ~fsync_q;

    case (state_q)
      IDLE: begin
        // The done cycle still counts as busy for request acceptance.
        if (CFG_REQ && !done_q) begin
          word_d  = CFG_WORD;
          state_d = PEND;
        end
      end
      PEND: begin
        if (FRAME_END) begin
          cnt_d   = '0;
          state_d = DELAY;
        end
      end
      DELAY, SEND, STOP: begin
        if (sync_edge) begin
          state_d = PEND;
          cnt_d   = '0;
          bcnt_d  = '0;
          ph_d    = 1'b0;
          out_d   = 1'b0;
          oe_d    = 1'b0;
          err_d   = 1'b1;
        end else if (state_q == DELAY) begin
          if (cnt_q == DLY_LAST) begin
            state_d = SEND;
            cnt_d   = '0;
            bcnt_d  = '0;
            ph_d    = 1'b0;
            sr_d    = {1'b1, word_q};
            out_d   = 1'b1;
            oe_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (state_q == SEND) begin
          if (cnt_q == HB_LAST) begin
            cnt_d = '0;
            if (!ph_q) begin
              // Second half is always the complement of the bit value.
              ph_d  = 1'b1;
              out_d = ~sr_q[WORD_W];
            end else if (bcnt_q == BC_LAST) begin
              state_d = STOP;
              out_d   = 1'b0;
            end else begin
              sr_d   = sr_q << 1;
              ph_d   = 1'b0;
              bcnt_d = bcnt_q + 1'b1;
              out_d  = sr_q[WORD_W-1];
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == HB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset releases the line immediately.
  always_ff @(posedge SCLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      ph_q    <= 1'b0;
      word_q  <= '0;
      sr_q    <= '0;
      fsync_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      ph_q    <= ph_d;
      word_q  <= word_d;
      sr_q    <= sr_d;
      fsync_q <= fsync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
    end
  end

endmodule
